mandelbrot_scan_feeder: RTL

//  Raster scan generator and result collector for the Mandelbrot iteration pipeline.
//  - Walks a H_RES x V_RES pixel grid and issues one complex c (Q10.22) per cycle into the pipeline.
//  - Carries each pixel's x/y tag through a delay line matched to the pipeline latency.
//  - Pairs each returning overflow flag with its pixel, so downstream framebuffer logic gets (x, y, inside).

---
 rtl/mandelbrot_scan_feeder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mandelbrot_scan_feeder.sv
// Raster scan generator and result collector for the Mandelbrot iteration pipeline.
// Define MANDEL_FEED_COUNT_EN to add the inside_count output (inside pixels per frame).
module mandelbrot_scan_feeder #(
    parameter int WIDTH   = 32,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int LATENCY = 14,
    parameter int XW      = 10,
    parameter int YW      = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x_min,
    input  logic [WIDTH-1:0] y_max,
    input  logic [WIDTH-1:0] step,
    input  logic             pix_ready,
    output logic [WIDTH-1:0] c_real_out,
    output logic [WIDTH-1:0] c_imag_out,
    output logic             c_valid_out,
    input  logic             overflow_in,
    output logic [XW-1:0]    pix_x,
    output logic [YW-1:0]    pix_y,
    output logic             pix_inside,
    output logic             pix_valid,
    output logic             busy,
`ifdef MANDEL_FEED_COUNT_EN
    output logic [XW+YW-1:0] inside_count,
`endif
    output logic             done
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    state_t           state;
    logic [WIDTH-1:0] x_min_q;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] acc_re;
    logic [WIDTH-1:0] acc_im;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [XW-1:0]    tag_x;
    logic [YW-1:0]    tag_y;
    logic             tag_last;

    logic             dl_valid [LATENCY];
    logic             dl_last  [LATENCY];
    logic [XW-1:0]    dl_x     [LATENCY];
    logic [YW-1:0]    dl_y     [LATENCY];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            x_min_q     <= '0;
            step_q      <= '0;
            acc_re      <= '0;
            acc_im      <= '0;
            x           <= '0;
            y           <= '0;
            tag_x       <= '0;
            tag_y       <= '0;
            tag_last    <= 1'b0;
            c_real_out  <= '0;
            c_imag_out  <= '0;
            c_valid_out <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    c_valid_out <= 1'b0;
                    if (start) begin
                        x_min_q <= x_min;
                        step_q  <= step;
                        acc_re  <= x_min;
                        acc_im  <= y_max;
                        x       <= '0;
                        y       <= '0;
                        busy    <= 1'b1;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    c_valid_out <= pix_ready;
                    if (pix_ready) begin
                        c_real_out <= acc_re;
                        c_imag_out <= acc_im;
                        tag_x      <= x;
                        tag_y      <= y;
                        tag_last   <= (x == X_LAST) && (y == Y_LAST);
                        if (x == X_LAST) begin
                            x      <= '0;
                            acc_re <= x_min_q;
                            if (y == Y_LAST) begin
                                y     <= '0;
                                state <= DRAIN;
                            end else begin
                                y      <= y + 1'b1;
                                acc_im <= acc_im - step_q;
                            end
                        end else begin
                            x      <= x + 1'b1;
                            acc_re <= acc_re + step_q;
                        end
                    end
                end
                DRAIN: begin
                    c_valid_out <= 1'b0;
                    // The last pixel's tag carries its own marker, so the done cycle is exact.
                    if (dl_last[LATENCY-1]) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running tag line: the pipeline never stalls, so neither may this.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                dl_valid[i] <= 1'b0;
                dl_last[i]  <= 1'b0;
                dl_x[i]     <= '0;
                dl_y[i]     <= '0;
            end
        end else begin
            dl_valid[0] <= c_valid_out;
            dl_last[0]  <= c_valid_out && tag_last;
            dl_x[0]     <= tag_x;
            dl_y[0]     <= tag_y;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_last[i]  <= dl_last[i-1];
                dl_x[i]     <= dl_x[i-1];
                dl_y[i]     <= dl_y[i-1];
            end
        end
    end

    assign pix_valid  = dl_valid[LATENCY-1];
    assign pix_x      = dl_x[LATENCY-1];
    assign pix_y      = dl_y[LATENCY-1];
    assign done       = dl_last[LATENCY-1];
    assign pix_inside = pix_valid & ~overflow_in;

`ifdef MANDEL_FEED_COUNT_EN
    logic [XW+YW-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (state == IDLE && start) begin
            count_q <= '0;
        end else if (pix_valid && pix_inside) begin
            count_q <= count_q + 1'b1;
        end
    end

    // The flag arrives with the result, so the current pixel is folded in combinationally.
    assign inside_count = count_q + (XW+YW)'(pix_valid && pix_inside);
`endif

endmodule
